// File: rtl/u_rec_gen_if.sv
// Host-side word interface of the UART receiver: received word, status flags and valid/ack handshake.
interface u_rec_gen_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] rec_dataH;
  logic              rec_validH;
  logic              rec_ackH;
  logic              frame_errH;
  logic              parity_errH;
  logic              overrunH;

  modport master (output rec_dataH, rec_validH, frame_errH, parity_errH, overrunH, input rec_ackH);
  modport slave  (input rec_dataH, rec_validH, frame_errH, parity_errH, overrunH, output rec_ackH);
endinterface

// File: rtl/u_rec_gen.sv
// Parametrised UART receiver timed by an external OVS x baud tick, with framing/break/overrun handling.
// Optional parity cell enabled by defining U_REC_PARITY_EN.
module u_rec_gen #(
  parameter int DATA_W     = 8,
  parameter int OVS        = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic         sys_clk,
  input  logic         sys_rst_l,
  input  logic         tick_enH,
  input  logic         uart_dataH,
  u_rec_gen_if.master  recBus
);
  localparam int CW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] HALF = CW'(OVS/2 - 1);
  localparam logic [CW-1:0] FULL = CW'(OVS - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  if (DATA_W < 5 || DATA_W > 9 || OVS < 4 || OVS > 32 || (OVS % 2) != 0 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_badCfg
    $error("u_rec_gen: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

  state_t            state;
  logic              sync1, rxs;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bitCnt;
  logic              stopCnt;
  logic [DATA_W-1:0] shReg;
  logic              frameFlag;
  logic              loadP, ldFrame;
  logic [DATA_W-1:0] dataQ;
  logic              validQ, frameQ, ovrQ;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge sys_clk or negedge sys_rst_l)
    if (!sys_rst_l) {sync1, rxs} <= 2'b11;
    else            {sync1, rxs} <= {uart_dataH, sync1};

`ifdef U_REC_PARITY_EN
  localparam logic PAR_ODD = 1'(PARITY_ODD);
  localparam state_t AFTER_DATA = PARITY;
  logic parBit, ldPar, parQ;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state     <= IDLE;
      cnt       <= '0;
      bitCnt    <= '0;
      stopCnt   <= 1'b0;
      shReg     <= '0;
      frameFlag <= 1'b0;
      loadP     <= 1'b0;
      ldFrame   <= 1'b0;
`ifdef U_REC_PARITY_EN
      parBit    <= 1'b0;
      ldPar     <= 1'b0;
`endif
    end else begin
      loadP <= 1'b0;
      case (state)
        IDLE: if (!rxs) begin
          state <= START;
          cnt   <= '0;
        end
        START: if (tick_enH) begin
          if (cnt == HALF) begin
            cnt       <= '0;
            bitCnt    <= '0;
            frameFlag <= 1'b0;
            state     <= rxs ? IDLE : DATA;
          end else cnt <= cnt + 1'b1;
        end
        DATA: if (tick_enH) begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shReg <= {rxs, shReg[DATA_W-1:1]};
            if (bitCnt == LAST_BIT) begin
              bitCnt  <= '0;
              stopCnt <= 1'b0;
              state   <= AFTER_DATA;
            end else bitCnt <= bitCnt + 1'b1;
          end else cnt <= cnt + 1'b1;
        end
`ifdef U_REC_PARITY_EN
        PARITY: if (tick_enH) begin
          if (cnt == FULL) begin
            cnt    <= '0;
            parBit <= rxs;
            state  <= STOP;
          end else cnt <= cnt + 1'b1;
        end
`endif
        STOP: if (tick_enH) begin
          if (cnt == FULL) begin
            cnt <= '0;
            if (stopCnt == LAST_STOP) begin
              loadP   <= 1'b1;
              ldFrame <= frameFlag | ~rxs;
`ifdef U_REC_PARITY_EN
              ldPar   <= (^{shReg, parBit}) ^ PAR_ODD;
`endif
              // A low final stop sample means the line may be in break: hold off until it idles.
              state   <= rxs ? IDLE : BRK;
            end else begin
              frameFlag <= frameFlag | ~rxs;
              stopCnt   <= 1'b1;
            end
          end else cnt <= cnt + 1'b1;
        end
        BRK: if (rxs) state <= IDLE;
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Handshake runs every cycle regardless of tick_enH.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      dataQ  <= '0;
      validQ <= 1'b0;
      frameQ <= 1'b0;
      ovrQ   <= 1'b0;
`ifdef U_REC_PARITY_EN
      parQ   <= 1'b0;
`endif
    end else begin
      ovrQ <= 1'b0;
      if (loadP) begin
        dataQ  <= shReg;
        frameQ <= ldFrame;
        validQ <= 1'b1;
        ovrQ   <= validQ & ~recBus.rec_ackH;
`ifdef U_REC_PARITY_EN
        parQ   <= ldPar;
`endif
      end else if (validQ && recBus.rec_ackH) begin
        validQ <= 1'b0;
      end
    end
  end

  assign recBus.rec_dataH  = dataQ;
  assign recBus.rec_validH = validQ;
  assign recBus.frame_errH = frameQ;
  assign recBus.overrunH   = ovrQ;
`ifdef U_REC_PARITY_EN
  assign recBus.parity_errH = parQ;
`else
  assign recBus.parity_errH = 1'b0;
`endif
endmodule
